// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter/sequencer for a bank of negedge toggle cells, with a shadow copy of the bank.
// Optional requester lock (HOLD state) is built when TFF_LOCK_EN is defined.
module tff_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_clr,
  input  logic [NUM_REQ*WIDTH-1:0] i_mask,
`ifdef TFF_LOCK_EN
  input  logic [NUM_REQ-1:0]       i_lock,
`endif
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic                     o_bank_we,
  output logic [WIDTH-1:0]         o_bank_d,
  output logic                     o_bank_reset,
  output logic                     o_busy,
  output logic [WIDTH-1:0]         o_shadow_q
);

  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

`ifdef TFF_LOCK_EN
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1} state_t;
`endif

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_bank_we;
  logic [WIDTH-1:0]   r_bank_d;
  logic               r_bank_reset;
  logic               r_busy;
  logic [WIDTH-1:0]   r_shadow;
`ifdef TFF_LOCK_EN
  logic [PW-1:0]      r_hold_idx;
  logic [NUM_REQ-1:0] w_hold_oh;
  logic               w_lock_hold;
`endif

  logic [WIDTH-1:0]   w_shadow_now;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [PW-1:0]      w_win;
  logic [WIDTH-1:0]   w_mask_w;
  logic [WIDTH-1:0]   w_d;
  logic [PW-1:0]      w_ptr_next;

  // Eligible set, rotating winner search and the op data for the winner
  always_comb begin
    // Clears must see the op still in flight, so fold the pending data into the shadow.
    w_shadow_now = r_shadow ^ r_bank_d;
`ifdef TFF_LOCK_EN
    w_hold_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_hold_idx;
    w_lock_hold = (r_state == ST_HOLD) && i_lock[r_hold_idx];
    if (w_lock_hold) begin
      w_elig = i_req & w_hold_oh;
    end else if (r_state == ST_HOLD) begin
      w_elig = i_req & ~w_hold_oh;
    end else begin
      w_elig = i_req & ~r_grant;
    end
`else
    w_elig = i_req & ~r_grant;
`endif
    w_found = 1'b0;
    w_win   = {PW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end else begin
        w_found = w_found;
      end
    end
    w_mask_w = i_mask[int'(w_win)*WIDTH +: WIDTH];
    if (!w_found) begin
      w_d = {WIDTH{1'b0}};
    end else if (i_clr[w_win]) begin
      w_d = w_mask_w & w_shadow_now;
    end else begin
      w_d = w_mask_w;
    end
    if (w_win == PW'(NUM_REQ - 1)) begin
      w_ptr_next = {PW{1'b0}};
    end else begin
      w_ptr_next = w_win + PW'(1);
    end
  end

  // Sequencer state, rotation pointer, registered bank drive and shadow
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_INIT;
      r_ptr        <= {PW{1'b0}};
      r_grant      <= {NUM_REQ{1'b0}};
      r_bank_we    <= 1'b0;
      r_bank_d     <= {WIDTH{1'b0}};
      r_bank_reset <= 1'b1;
      r_busy       <= 1'b1;
      r_shadow     <= {WIDTH{1'b0}};
`ifdef TFF_LOCK_EN
      r_hold_idx   <= {PW{1'b0}};
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state      <= ST_IDLE;
          r_grant      <= {NUM_REQ{1'b0}};
          r_bank_we    <= 1'b0;
          r_bank_d     <= {WIDTH{1'b0}};
          r_bank_reset <= 1'b1;
          r_busy       <= 1'b1;
          r_shadow     <= {WIDTH{1'b0}};
        end
`ifdef TFF_LOCK_EN
        ST_IDLE, ST_HOLD: begin
`else
        ST_IDLE: begin
`endif
          r_grant      <= w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : {NUM_REQ{1'b0}};
          r_bank_d     <= w_d;
          r_bank_we    <= (w_d != {WIDTH{1'b0}});
          r_bank_reset <= 1'b0;
          r_shadow     <= w_shadow_now;
          if (w_found) begin
            r_ptr <= w_ptr_next;
          end else begin
            r_ptr <= r_ptr;
          end
`ifdef TFF_LOCK_EN
          if (w_found && i_lock[w_win]) begin
            r_state    <= ST_HOLD;
            r_hold_idx <= w_win;
            r_busy     <= 1'b1;
          end else if (w_lock_hold) begin
            r_state <= ST_HOLD;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
`else
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state      <= ST_INIT;
          r_grant      <= {NUM_REQ{1'b0}};
          r_bank_we    <= 1'b0;
          r_bank_d     <= {WIDTH{1'b0}};
          r_bank_reset <= 1'b1;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_ack        = r_grant;
  assign o_bank_we    = r_bank_we;
  assign o_bank_d     = r_bank_d;
  assign o_bank_reset = r_bank_reset;
  assign o_busy       = r_busy;
  assign o_shadow_q   = r_shadow;

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Bench for tff_bank_arbiter: behavioural bank model checked every cycle plus literal pins.
module tb_tff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, clr, lock;
  logic [N*W-1:0] mask;
  logic [N-1:0]   o_grant, o_ack;
  logic           o_bank_we, o_bank_reset, o_busy;
  logic [W-1:0]   o_bank_d, o_shadow_q;

  tff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_clr(clr), .i_mask(mask),
`ifdef TFF_LOCK_EN
    .i_lock(lock),
`endif
    .o_grant(o_grant), .o_ack(o_ack), .o_bank_we(o_bank_we), .o_bank_d(o_bank_d),
    .o_bank_reset(o_bank_reset), .o_busy(o_busy), .o_shadow_q(o_shadow_q)
  );

  always #5 clk = ~clk;

  // model state: mode 0=init pending, 1=run, 2=hold
  int           m_mode, m_ptr, m_last, m_hw;
  logic [W-1:0] m_bank;
  logic [N-1:0] exp_grant;
  logic         exp_we, exp_reset, exp_busy;
  logic [W-1:0] exp_d, exp_shadow;

  logic         chk_en = 1'b0;
  logic         lit_on  [0:6];
  logic [31:0]  lit_val [0:6];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Compare DUT against model every cycle, plus any literal pins for this cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("grant", 32'(o_grant), 32'(exp_grant));
      cmp("ack", 32'(o_ack), 32'(exp_grant));
      cmp("bank_we", 32'(o_bank_we), 32'(exp_we));
      cmp("bank_d", 32'(o_bank_d), 32'(exp_d));
      cmp("bank_reset", 32'(o_bank_reset), 32'(exp_reset));
      cmp("busy", 32'(o_busy), 32'(exp_busy));
      cmp("shadow_q", 32'(o_shadow_q), 32'(exp_shadow));
      if (lit_on[0]) cmp("lit_grant", 32'(o_grant), lit_val[0]);
      if (lit_on[1]) cmp("lit_ack", 32'(o_ack), lit_val[1]);
      if (lit_on[2]) cmp("lit_bank_we", 32'(o_bank_we), lit_val[2]);
      if (lit_on[3]) cmp("lit_bank_d", 32'(o_bank_d), lit_val[3]);
      if (lit_on[4]) cmp("lit_bank_reset", 32'(o_bank_reset), lit_val[4]);
      if (lit_on[5]) cmp("lit_busy", 32'(o_busy), lit_val[5]);
      if (lit_on[6]) cmp("lit_shadow_q", 32'(o_shadow_q), lit_val[6]);
    end
  end

  // What the outputs must be after this edge, from the arbitration rules and true bank contents
  task automatic model_step();
    int win;
    int excl;
    logic [W-1:0] mw;
    logic [W-1:0] d;
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_last = -1; m_bank = '0;
      exp_grant = '0; exp_we = 1'b0; exp_d = '0;
      exp_reset = 1'b1; exp_busy = 1'b1; exp_shadow = '0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_last = -1;
      exp_grant = '0; exp_we = 1'b0; exp_d = '0;
      exp_reset = 1'b1; exp_busy = 1'b1; exp_shadow = '0;
    end else begin
      exp_shadow = m_bank;
      exp_reset  = 1'b0;
      win = -1;
      if (m_mode == 2 && lock[m_hw]) begin
        if (req[m_hw]) win = m_hw;
      end else begin
        excl = (m_mode == 2) ? m_hw : m_last;
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr + k) % N;
          if (win < 0 && req[i] && i != excl) win = i;
        end
      end
      if (win >= 0) begin
        mw = mask[win*W +: W];
        if (clr[win]) begin
          d = mw & m_bank;
          m_bank = m_bank & ~mw;
        end else begin
          d = mw;
          m_bank = m_bank ^ mw;
        end
        exp_grant = N'(1) << win;
        exp_d = d;
        exp_we = (d != '0);
        m_ptr = (win + 1) % N;
        m_last = win;
        if (lock[win]) begin m_mode = 2; m_hw = win; end
        else m_mode = 1;
      end else begin
        exp_grant = '0; exp_d = '0; exp_we = 1'b0; m_last = -1;
        if (!(m_mode == 2 && lock[m_hw])) m_mode = 1;
      end
      exp_busy = (m_mode == 2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    for (int f = 0; f < 7; f++) lit_on[f] = 1'b0;
  endtask

  task automatic pin(input int f, input logic [31:0] v);
    lit_on[f] = 1'b1;
    lit_val[f] = v;
  endtask

  task automatic set_mask(input int i, input logic [W-1:0] m);
    mask[i*W +: W] = m;
  endtask

  initial begin
    for (int f = 0; f < 7; f++) begin lit_on[f] = 1'b0; lit_val[f] = '0; end
    rst_n = 1'b0; req = '0; clr = '0; lock = '0; mask = '0;
    m_mode = 0; m_ptr = 0; m_last = -1; m_hw = 0; m_bank = '0;
    chk_en = 1'b1;

    // Reset for two cycles, then exactly one more cycle of bank reset
    pin(4, 32'd1); pin(0, 32'd0); pin(6, 32'd0); pin(5, 32'd1); tick();
    pin(4, 32'd1); tick();
    rst_n = 1'b1; req = 4'b0010; set_mask(1, 16'h00F0);
    pin(4, 32'd1); pin(0, 32'd0); tick();
    pin(4, 32'd0); pin(1, 32'h2); pin(2, 32'd1); pin(3, 32'h00F0); tick();
    req = '0;
    pin(6, 32'h00F0); pin(0, 32'd0); pin(2, 32'd0); tick();

    // Clear from 00F0, then repeat the clear on already-zero bits
    req = 4'b0100; clr = 4'b0100; set_mask(2, 16'h0FF0);
    pin(0, 32'h4); pin(3, 32'h00F0); pin(2, 32'd1); tick();
    req = '0; pin(6, 32'h0000); tick();
    req = 4'b0100;
    pin(1, 32'h4); pin(2, 32'd0); pin(3, 32'h0000); tick();
    req = '0; clr = '0; tick();

    // Mask of zero still acks without a write
    req = 4'b0001; set_mask(0, 16'h0000);
    pin(0, 32'h1); pin(2, 32'd0); tick();
    req = '0; tick();

    // Rotation from pointer 0 with all four requesting
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b1111;
    set_mask(0, 16'h0001); set_mask(1, 16'h0030); set_mask(2, 16'h0700); set_mask(3, 16'hF000);
    pin(0, 32'd0); tick();
    pin(0, 32'h1); tick();
    pin(0, 32'h2); tick();
    pin(0, 32'h4); tick();
    pin(0, 32'h8); tick();
    pin(0, 32'h1); pin(6, 32'hF731); tick();
    clr = 4'b0110;
    for (int i = 0; i < 4; i++) tick();
    req = '0; clr = '0; tick();

    // Reset while requester 3 is being acked
    req = 4'b1000; pin(0, 32'h8); tick();
    rst_n = 1'b0;
    pin(1, 32'd0); pin(2, 32'd0); pin(4, 32'd1); pin(6, 32'd0); pin(5, 32'd1); tick();
    rst_n = 1'b1; req = '0; tick();
    req = 4'b0110; pin(0, 32'h2); tick();
    req = '0; tick();

    // Directed mixed traffic table
    set_mask(0, 16'hA5A5); set_mask(1, 16'h0F0F); set_mask(2, 16'hFF00); set_mask(3, 16'h1234);
    for (int i = 0; i < 12; i++) begin
      req = 4'((i * 5 + 3) % 16);
      clr = 4'((i * 3) % 16);
      tick();
    end
    req = '0; clr = '0; tick();

`ifdef TFF_LOCK_EN
    // Requester 0 locks for three ops while requester 2 waits
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    req = 4'b0101; lock = 4'b0001;
    pin(0, 32'h1); pin(5, 32'd1); tick();
    pin(0, 32'h1); pin(5, 32'd1); tick();
    pin(0, 32'h1); pin(5, 32'd1); tick();
    lock = '0;
    pin(0, 32'h4); pin(5, 32'd0); tick();
    req = '0; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
